mul_eight_seq: RTL and testbench
================================

Name: mul_eight_seq

Overview:
- Sequential 8x8 unsigned shift-and-add multiplier for the CPU datapath.
- Loads two 8-bit operands, then drives the existing 8-bit ripple adder (addEight) once per cycle for 8 cycles.
- Consumes the adder's sum and carry-out and returns a registered 16-bit product with a start/busy/done handshake.
- Sits between the operand register file and the writeback mux, alongside the adder.

Parameters:
- None. The datapath is fixed at 8 bits to match addEight.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a multiply; sampled on the rising edge of clk
- opA  input  8  multiplicand, captured when start is accepted
- opB  input  8  multiplier, captured when start is accepted
- busy  output  1  high while an iteration sequence is in progress
- done  output  1  single-cycle pulse: product is valid
- product  output  16  registered result {hi,lo}; holds until the next completion
- zero  output  1  registered flag: product == 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; busy = 0; done = 0; product = 0x0000; zero = 1.
  - Internal hi, lo, mcand and count registers clear to 0.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - start is accepted only in IDLE or DONE. On the accepting edge E0: mcand <= opA, lo <= opB, hi <= 0, count <= 0, state -> RUN.
  - start while in RUN is ignored. Operand inputs are don't-care outside the accepting edge.
- RUN (edges E1..E8), one iteration per edge:
  - Adder instance: dIn0 = hi; dIn1 = lo[0] ? mcand : 8'h00; enable tied 1.
  - hi <= {cOut, sum[7:1]}; lo <= {sum[0], lo[7:1]}; count <= count + 1.
  - count is 3 bits. The iteration with count == 7 is the last: state -> DONE, product <= next {hi,lo}, zero <= (next {hi,lo} == 0).
- Timing:
  - busy = (state == RUN), registered output. High in the 8 cycles after E0.
  - done = (state == DONE). High for exactly one cycle after E8, i.e. 9 edges after the start edge.
- DONE:
  - start high: accept a new operation (back-to-back, no IDLE cycle); done drops next cycle.
  - start low: state -> IDLE.
- product and zero change only on entry to DONE or on reset. They never show intermediate partial products.
- Arithmetic:
  - Unsigned only. The 16-bit result is exact; no overflow is possible (max 255*255 = 0xFE01).
  - The adder carry-out is part of the shifted value, not a flag.
- Reset mid-RUN aborts immediately to reset values; no done pulse is produced.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the constant MUL_ITERS = 8.
- One sub-module: the existing addEight, instantiated as the per-iteration adder. No other sub-modules.

Test Plan:
- Basic multiply: start with opA=13, opB=11 -> busy high 8 cycles, done pulse 9 edges after start, product=0x008F, zero=0.
- Full-carry stress: opA=0xFF, opB=0xFF -> product=0xFE01. Exercises adder cOut on every iteration.
- Zero operand: opA=0x00, opB=0xA5 -> product=0x0000, zero=1. Then opA=0x01, opB=0x80 -> product=0x0080, zero=0.
- Ignored start: assert start (opA=2, opB=3) in RUN mid-way through a 6*7 multiply -> product=0x002A, only one done pulse, busy not extended.
- Back-to-back: start held high in the DONE cycle with opA=3, opB=5 -> the next operation begins without an IDLE cycle. The first product (e.g. 0x002A) holds until the second done, then product=0x000F.
- Reset mid-operation: drop rst_n in the 4th RUN cycle -> outputs go immediately to busy=0, done=0, product=0x0000, zero=1. No done pulse follows. A subsequent start completes normally.

Source files
------------

// File: rtl/mul_eight_seq_pkg.sv
// rtl/mul_eight_seq_pkg.sv - shared constants for the sequential 8x8 multiplier
package mul_eight_seq_pkg;

    // FSM encoding kept as plain 2-bit constants so older tools and netlists line up
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // One adder pass per multiplier bit
    localparam int MUL_ITERS = 8;

    // Value of the 3-bit iteration counter during the final pass
    localparam logic [2:0] LAST_COUNT = 3'(MUL_ITERS - 1);

endpackage

// File: rtl/mul_eight_seq_add_eight.sv
// rtl/mul_eight_seq_add_eight.sv - 8-bit ripple-carry adder (addEight) used per iteration
module mul_eight_seq_add_eight (
    input  logic [7:0] i_din0,
    input  logic [7:0] i_din1,
    input  logic       i_enable,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    logic [8:0] w_carry;
    logic [7:0] w_sum;

    assign w_carry[0] = 1'b0;

    // Full-adder chain, carry rippling from bit 0 upward
    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_fa
            assign w_sum[g]       = i_din0[g] ^ i_din1[g] ^ w_carry[g];
            assign w_carry[g + 1] = (i_din0[g] & i_din1[g]) |
                                    (i_din0[g] & w_carry[g]) |
                                    (i_din1[g] & w_carry[g]);
        end
    endgenerate

    // A disabled adder presents all-zero outputs
    assign o_sum  = i_enable ? w_sum : 8'h00;
    assign o_cout = i_enable & w_carry[8];

endmodule

// File: rtl/mul_eight_seq.sv
// rtl/mul_eight_seq.sv - sequential 8x8 unsigned shift-and-add multiplier
module mul_eight_seq
    import mul_eight_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  opA,
    input  logic [7:0]  opB,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        zero
);

    logic [1:0]  r_state;
    logic [7:0]  r_hi;
    logic [7:0]  r_lo;
    logic [7:0]  r_mcand;
    logic [2:0]  r_count;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_product;
    logic        r_zero;

    logic [7:0]  w_addend;
    logic [7:0]  w_sum;
    logic        w_cout;
    logic [7:0]  w_next_hi;
    logic [7:0]  w_next_lo;

    // Add the multiplicand only when the current multiplier bit is set
    assign w_addend = r_lo[0] ? r_mcand : 8'h00;

    mul_eight_seq_add_eight u_add_eight (
        .i_din0   (r_hi),
        .i_din1   (w_addend),
        .i_enable (1'b1),
        .o_sum    (w_sum),
        .o_cout   (w_cout)
    );

    // The carry-out becomes the new top bit of the shifted partial product
    assign w_next_hi = {w_cout, w_sum[7:1]};
    assign w_next_lo = {w_sum[0], r_lo[7:1]};

    // Control FSM plus the hi/lo shift register and the published result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_hi      <= 8'h00;
            r_lo      <= 8'h00;
            r_mcand   <= 8'h00;
            r_count   <= 3'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= 16'h0000;
            r_zero    <= 1'b1;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_mcand <= opA;
                        r_lo    <= opB;
                        r_hi    <= 8'h00;
                        r_count <= 3'd0;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    r_done <= 1'b0;
                end
                RUN: begin
                    r_hi    <= w_next_hi;
                    r_lo    <= w_next_lo;
                    r_count <= r_count + 3'd1;
                    if (r_count == LAST_COUNT) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_product <= {w_next_hi, w_next_lo};
                        r_zero    <= ({w_next_hi, w_next_lo} == 16'h0000);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;
    assign zero    = r_zero;

endmodule

// File: tb/tb_mul_eight_seq.sv
// tb/tb_mul_eight_seq.sv - self-checking bench for mul_eight_seq
module tb_mul_eight_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  opA = 8'h00;
    logic [7:0]  opB = 8'h00;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        zero;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] last_prod = 16'h0000;

    mul_eight_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .opA     (opA),
        .opB     (opB),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zero    (zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        start = 1'b1;
        opA   = a;
        opB   = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        opA   = 8'($urandom);
        opB   = 8'($urandom);
    endtask

    // Full operation: latency, busy length, held product, final result
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input int inject_at);
        int          cycles   = 1;
        int          busy_cnt = 0;
        int          held     = 1;
        logic [15:0] exp_prod;
        exp_prod = 16'(a) * 16'(b);
        start_op(a, b);
        check_eq({tag, "_done_low_after_start"}, done, 0);
        while (!done && cycles < 20) begin
            if (busy) busy_cnt++;
            if (product !== last_prod) held = 0;
            if (cycles == inject_at) begin
                start = 1'b1;
                opA   = 8'd2;
                opB   = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, cycles, 9);
        check_eq({tag, "_busy_cycles"}, busy_cnt, 8);
        check_eq({tag, "_product_held"}, held, 1);
        check_eq({tag, "_busy_at_done"}, busy, 0);
        check_eq({tag, "_product"}, product, exp_prod);
        check_eq({tag, "_zero"}, zero, (exp_prod == 16'h0000));
        last_prod = exp_prod;
    endtask

    // One cycle after done with start low: back in IDLE, result held
    task automatic idle_check(input string tag);
        @(negedge clk);
        check_eq({tag, "_done_pulse_1cyc"}, done, 0);
        check_eq({tag, "_idle_busy"}, busy, 0);
        check_eq({tag, "_idle_product"}, product, last_prod);
    endtask

    initial begin
        int          done_seen;
        logic [7:0]  ra;
        logic [7:0]  rb;

        repeat (2) @(negedge clk);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_product", product, 16'h0000);
        check_eq("reset_zero", zero, 1);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("basic_13x11", 8'd13, 8'd11, -1);
        idle_check("basic_13x11");
        run_op("full_carry", 8'hFF, 8'hFF, -1);
        idle_check("full_carry");
        run_op("zero_op", 8'h00, 8'hA5, -1);
        idle_check("zero_op");
        run_op("one_x80", 8'h01, 8'h80, -1);
        idle_check("one_x80");

        run_op("ignored_start", 8'd6, 8'd7, 4);
        idle_check("ignored_start");

        run_op("b2b_first", 8'd6, 8'd7, -1);
        run_op("b2b_second", 8'd3, 8'd5, -1);
        idle_check("b2b_second");

        start_op(8'd6, 8'd7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midreset_busy", busy, 0);
        check_eq("midreset_done", done, 0);
        check_eq("midreset_product", product, 16'h0000);
        check_eq("midreset_zero", zero, 1);
        @(negedge clk);
        rst_n = 1'b1;
        last_prod = 16'h0000;
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check_eq("midreset_no_done", done_seen, 0);
        run_op("after_reset", 8'd2, 8'd9, -1);
        idle_check("after_reset");

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ((i % 7) == 0) rb = 8'h00;
            run_op("random", ra, rb, ((i % 5) == 0) ? 3 : -1);
            if ($urandom_range(0, 1) == 1) idle_check("random");
        end
        idle_check("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
